// File: rtl/lab72_pio_pkg.sv
// Shared types and helpers for the lab72 PIO poll master and its debounce stage.
package lab72_pio_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } poll_state_e;

  localparam int PIO_DATA_ADDR = 0;

  function automatic int deb_cnt_w(input int samples);
    return $clog2(samples + 1);
  endfunction

endpackage

// File: rtl/lab72_debounce_edge.sv
// Debounces a stream of sampled 1-bit levels and emits single-cycle edge pulses
// aligned with the change of the clean level.
module lab72_debounce_edge
  import lab72_pio_pkg::*;
#(
  parameter int DEBOUNCE_SAMPLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_valid,
  input  logic sample,
  output logic level,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int CW = deb_cnt_w(DEBOUNCE_SAMPLES);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SAMPLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Count consecutive samples that disagree with the clean level; the last one flips it.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (sample_valid) begin
      if (sample == level_q) begin
        cnt_d = CNT_ZERO;
      end else if (cnt_q == CNT_LAST) begin
        cnt_d   = CNT_ZERO;
        level_d = ~level_q;
        rise_d  = ~level_q;
        fall_d  = level_q;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= CNT_ZERO;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level      = level_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: rtl/lab72_pio_poll_master.sv
// Avalon-MM read initiator that periodically polls a 1-bit PIO data register and
// hands the sampled pin to a debouncer producing a clean level and edge pulses.
module lab72_pio_poll_master
  import lab72_pio_pkg::*;
#(
  parameter int POLL_INTERVAL    = 50000,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter int ADDR_W           = 2,
  parameter int TARGET_ADDR      = PIO_DATA_ADDR,
  parameter int READ_LATENCY     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  output logic              level,
  output logic              rise_pulse,
  output logic              fall_pulse,
  output logic              busy
);

  localparam int                IW         = $clog2(POLL_INTERVAL);
  localparam logic [IW-1:0]     IVL_ZERO   = {IW{1'b0}};
  localparam logic [IW-1:0]     IVL_ONE    = IW'(1);
  localparam logic [IW-1:0]     IVL_RELOAD = IW'(POLL_INTERVAL - 1);
  localparam logic [1:0]        LAT_RELOAD = 2'(READ_LATENCY - 1);
  localparam logic [ADDR_W-1:0] ADDR_VAL   = ADDR_W'(TARGET_ADDR);

  poll_state_e       state_q, state_d;
  logic [IW-1:0]     ivl_q, ivl_d;
  logic [1:0]        lat_q, lat_d;
  logic              read_q, read_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              tick_s;
  logic              sample_valid_s;
  logic              sample_s;
  logic              readdata_unused_s;

  assign sample_s          = avm_readdata[0];
  assign readdata_unused_s = ^avm_readdata[31:1];

  // Free-running poll interval counter; frozen while polling is disabled.
  always_comb begin
    tick_s = 1'b0;
    ivl_d  = ivl_q;
    if (enable) begin
      if (ivl_q == IVL_ZERO) begin
        ivl_d  = IVL_RELOAD;
        tick_s = 1'b1;
      end else begin
        ivl_d = ivl_q - IVL_ONE;
      end
    end else begin
      ivl_d = ivl_q;
    end
  end

  // Poll FSM: ticks outside IDLE are simply lost, so polls never queue up.
  always_comb begin
    state_d        = state_q;
    lat_d          = lat_q;
    read_d         = 1'b0;
    addr_d         = ADDR_VAL;
    sample_valid_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick_s) begin
          state_d = REQ;
          read_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (!avm_waitrequest) begin
          state_d = WAIT;
          lat_d   = LAT_RELOAD;
        end else begin
          read_d = 1'b1;
        end
      end
      WAIT: begin
        if (lat_q == 2'd0) begin
          state_d        = IDLE;
          sample_valid_s = 1'b1;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // Control and bus-facing registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ivl_q   <= IVL_RELOAD;
      lat_q   <= 2'd0;
      read_q  <= 1'b0;
      busy_q  <= 1'b0;
      addr_q  <= ADDR_VAL;
    end else begin
      state_q <= state_d;
      ivl_q   <= ivl_d;
      lat_q   <= lat_d;
      read_q  <= read_d;
      busy_q  <= busy_d;
      addr_q  <= addr_d;
    end
  end

  lab72_debounce_edge #(
    .DEBOUNCE_SAMPLES(DEBOUNCE_SAMPLES)
  ) u_debounce (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid_s),
    .sample       (sample_s),
    .level        (level),
    .rise_pulse   (rise_pulse),
    .fall_pulse   (fall_pulse)
  );

  assign avm_address = addr_q;
  assign avm_read    = read_q;
  assign busy        = busy_q;

endmodule
